// File: rtl/dft_rdx4.sv
// Fully pipelined 4-point complex DFT butterfly (2-cycle latency, 5-lane ports, lane 4 unused).
// Optional macro DFT_RDX4_SAT_EN saturates the outputs instead of wrapping them.
module dft_rdx4 #(
    parameter int wDataInOut = 30
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_val,
    input  logic signed [wDataInOut-1:0] din_real  [0:4],
    input  logic signed [wDataInOut-1:0] din_imag  [0:4],
    output logic                         out_val,
    output logic signed [wDataInOut-1:0] dout_real [0:4],
    output logic signed [wDataInOut-1:0] dout_imag [0:4]
);

    localparam int W1 = wDataInOut + 1;
    localparam int W2 = wDataInOut + 2;

`ifdef DFT_RDX4_SAT_EN
    localparam logic signed [W2-1:0] SAT_MAX = {3'b000, {(wDataInOut-1){1'b1}}};
    localparam logic signed [W2-1:0] SAT_MIN = {3'b111, {(wDataInOut-1){1'b0}}};
`endif

    logic                 v1;
    logic signed [W1-1:0] a_re, a_im, b_re, b_im, c_re, c_im, d_re, d_im;
    logic signed [W2-1:0] s_re [0:3];
    logic signed [W2-1:0] s_im [0:3];

    // Lane 4 exists only to match the shared lane structure.
    logic unused_lane4;
    assign unused_lane4 = ^{din_real[4], din_imag[4]};

    function automatic logic signed [wDataInOut-1:0] fit(input logic signed [W2-1:0] v);
`ifdef DFT_RDX4_SAT_EN
        if (v > SAT_MAX)
            fit = SAT_MAX[wDataInOut-1:0];
        else if (v < SAT_MIN)
            fit = SAT_MIN[wDataInOut-1:0];
        else
            fit = v[wDataInOut-1:0];
`else
        fit = v[wDataInOut-1:0];
`endif
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            v1   <= 1'b0;
            a_re <= '0;
            a_im <= '0;
            b_re <= '0;
            b_im <= '0;
            c_re <= '0;
            c_im <= '0;
            d_re <= '0;
            d_im <= '0;
        end else begin
            v1 <= in_val;
            if (in_val) begin
                a_re <= W1'(din_real[0]) + W1'(din_real[2]);
                a_im <= W1'(din_imag[0]) + W1'(din_imag[2]);
                b_re <= W1'(din_real[0]) - W1'(din_real[2]);
                b_im <= W1'(din_imag[0]) - W1'(din_imag[2]);
                c_re <= W1'(din_real[1]) + W1'(din_real[3]);
                c_im <= W1'(din_imag[1]) + W1'(din_imag[3]);
                d_re <= W1'(din_real[1]) - W1'(din_real[3]);
                d_im <= W1'(din_imag[1]) - W1'(din_imag[3]);
            end
        end
    end

    // The +/-j rotations of d are just swaps and negations, no multipliers needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_val <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                s_re[i] <= '0;
                s_im[i] <= '0;
            end
        end else begin
            out_val <= v1;
            if (v1) begin
                s_re[0] <= W2'(a_re) + W2'(c_re);
                s_im[0] <= W2'(a_im) + W2'(c_im);
                s_re[1] <= W2'(b_re) + W2'(d_im);
                s_im[1] <= W2'(b_im) - W2'(d_re);
                s_re[2] <= W2'(a_re) - W2'(c_re);
                s_im[2] <= W2'(a_im) - W2'(c_im);
                s_re[3] <= W2'(b_re) - W2'(d_im);
                s_im[3] <= W2'(b_im) + W2'(d_re);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            dout_real[i] = fit(s_re[i]);
            dout_imag[i] = fit(s_im[i]);
        end
        dout_real[4] = '0;
        dout_imag[4] = '0;
    end

endmodule

// File: tb/tb_dft_rdx4.sv
// Scoreboard bench for dft_rdx4: stimulus pushes model results, a negedge monitor pops and compares.
module tb_dft_rdx4;

    localparam int W = 30;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_val = 1'b0;
    logic signed [W-1:0] din_real  [0:4];
    logic signed [W-1:0] din_imag  [0:4];
    logic                out_val;
    logic signed [W-1:0] dout_real [0:4];
    logic signed [W-1:0] dout_imag [0:4];

    typedef struct {
        string               tag;
        int                  due;
        logic signed [W-1:0] re [4];
        logic signed [W-1:0] im [4];
    } exp_t;

    exp_t sb[$];
    exp_t last;
    int   cyc = 0;
    logic rst_q = 1'b1;
    int   nChecks = 0;
    int   nFail = 0;

    dft_rdx4 #(.wDataInOut(W)) dut (
        .clk(clk), .rst(rst), .in_val(in_val),
        .din_real(din_real), .din_imag(din_imag),
        .out_val(out_val), .dout_real(dout_real), .dout_imag(dout_imag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    function automatic logic signed [W-1:0] fitv(input longint v);
`ifdef DFT_RDX4_SAT_EN
        if (v > (64'sd1 <<< (W-1)) - 1) return W'((64'sd1 <<< (W-1)) - 1);
        if (v < -(64'sd1 <<< (W-1)))    return W'(-(64'sd1 <<< (W-1)));
`endif
        return v[W-1:0];
    endfunction

    function automatic longint rnd18();
        logic signed [17:0] t;
        t = 18'($urandom);
        return longint'(t);
    endfunction

    // Expected values come straight from the DFT definition, not from the butterfly split.
    task automatic applyStimulus(input string tag,
                                 input longint r0, i0, r1, i1, r2, i2, r3, i3);
        exp_t e;
        @(negedge clk);
        din_real[0] = r0[W-1:0]; din_imag[0] = i0[W-1:0];
        din_real[1] = r1[W-1:0]; din_imag[1] = i1[W-1:0];
        din_real[2] = r2[W-1:0]; din_imag[2] = i2[W-1:0];
        din_real[3] = r3[W-1:0]; din_imag[3] = i3[W-1:0];
        din_real[4] = W'($urandom);
        din_imag[4] = W'($urandom);
        in_val = 1'b1;
        e.tag   = tag;
        e.due   = cyc + 2;
        e.re[0] = fitv(r0 + r1 + r2 + r3);
        e.im[0] = fitv(i0 + i1 + i2 + i3);
        e.re[1] = fitv(r0 + i1 - r2 - i3);
        e.im[1] = fitv(i0 - r1 - i2 + r3);
        e.re[2] = fitv(r0 - r1 + r2 - r3);
        e.im[2] = fitv(i0 - i1 + i2 - i3);
        e.re[3] = fitv(r0 - i1 - r2 + i3);
        e.im[3] = fitv(i0 + r1 - i2 - r3);
        sb.push_back(e);
    endtask

    task automatic idleCycle();
        @(negedge clk);
        in_val = 1'b0;
        for (int i = 0; i < 5; i++) begin
            din_real[i] = W'($urandom);
            din_imag[i] = W'($urandom);
        end
    endtask

    task automatic checkOutput(input exp_t e, input string what);
        bit ok;
        ok = 1'b1;
        nChecks++;
        for (int i = 0; i < 4; i++) begin
            if (dout_real[i] !== e.re[i] || dout_imag[i] !== e.im[i]) begin
                ok = 1'b0;
                $display("[TB] FAIL %s/%s X%0d: got (%0d,%0d) expected (%0d,%0d) at cycle %0d",
                         what, e.tag, i, dout_real[i], dout_imag[i], e.re[i], e.im[i], cyc);
            end
        end
        if (dout_real[4] !== '0 || dout_imag[4] !== '0) begin
            ok = 1'b0;
            $display("[TB] FAIL %s/%s lane4: got (%0d,%0d) expected (0,0)",
                     what, e.tag, dout_real[4], dout_imag[4]);
        end
        if (!ok) nFail++;
    endtask

    // Monitor: reset clears everything, out_val pops the scoreboard, idle cycles must hold.
    always @(negedge clk) begin
        exp_t e;
        if (rst_q) begin
            e.tag = "reset";
            e.due = 0;
            for (int i = 0; i < 4; i++) begin
                e.re[i] = '0;
                e.im[i] = '0;
            end
            last = e;
            nChecks++;
            if (out_val !== 1'b0) begin
                nFail++;
                $display("[TB] FAIL reset_out_val: got %b expected 0", out_val);
            end
            checkOutput(e, "reset_dout");
        end else if (out_val === 1'b1) begin
            if (sb.size() == 0) begin
                nChecks++;
                nFail++;
                $display("[TB] FAIL spurious_out_val: got 1 expected 0 at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                nChecks++;
                if (e.due != cyc) begin
                    nFail++;
                    $display("[TB] FAIL latency/%s: got cycle %0d expected cycle %0d", e.tag, cyc, e.due);
                end
                checkOutput(e, "result");
                last = e;
            end
        end else begin
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                nChecks++;
                nFail++;
                $display("[TB] FAIL missing_out_val/%s: got 0 expected 1 at cycle %0d", e.tag, cyc);
            end
            checkOutput(last, "hold");
        end
    end

    localparam longint BIG = (64'sd1 <<< 29) - 1;

    initial begin
        for (int i = 0; i < 5; i++) begin
            din_real[i] = '0;
            din_imag[i] = '0;
        end

        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_val = k[0] ? 1'b0 : 1'b1;
            din_real[0] = W'($urandom);
            din_imag[1] = W'($urandom);
        end
        @(negedge clk);
        rst = 1'b0;
        in_val = 1'b0;

        applyStimulus("impulse", 1, 0, 0, 0, 0, 0, 0, 0);
        idleCycle(); idleCycle(); idleCycle();

        applyStimulus("lane1", 0, 0, 1, 0, 0, 0, 0, 0);
        idleCycle(); idleCycle();

        applyStimulus("lane3_imag", 0, 0, 0, 0, 0, 0, 0, 5);
        idleCycle(); idleCycle();

        for (int k = 0; k < 3; k++) applyStimulus("dc_b2b", 1, 2, 1, 2, 1, 2, 1, 2);
        idleCycle(); idleCycle(); idleCycle();

        applyStimulus("neg_mix", -7, 3, 11, -2, -5, -9, 4, 6);
        idleCycle(); idleCycle(); idleCycle();

        applyStimulus("overflow", BIG, 0, BIG, 0, BIG, 0, BIG, 0);
        idleCycle(); idleCycle(); idleCycle();

        applyStimulus("underflow", -BIG - 1, 0, -BIG - 1, 0, -BIG - 1, 0, -BIG - 1, 0);
        idleCycle(); idleCycle(); idleCycle();

        // Reset while a vector is in flight: it must vanish without an out_val pulse.
        applyStimulus("flushed", 9, 9, 9, 9, 9, 9, 9, 9);
        @(negedge clk);
        rst = 1'b1;
        in_val = 1'b1;
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        in_val = 1'b0;
        idleCycle(); idleCycle();

        for (int k = 0; k < 1000; k++)
            applyStimulus("random", rnd18(), rnd18(), rnd18(), rnd18(),
                          rnd18(), rnd18(), rnd18(), rnd18());
        idleCycle();

        for (int k = 0; k < 10 && sb.size() > 0; k++) idleCycle();
        nChecks++;
        if (sb.size() != 0) begin
            nFail++;
            $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
